pc_sequencer: RTL

Parametrised program-counter register and next-PC sequencer for the IF stage of the pipelined MIPS core. It generalises the fixed PC+4 incrementor: configurable width, step and reset vector; prioritised redirect (exception, jump, branch); stall handling; redirect capture during stall; and target alignment checking. Outputs feed instruction memory and the IF/ID pipeline register.

---
 rtl/pc_pkg.sv | 20 ++
 rtl/pc_incrementor.sv | 12 +
 rtl/pc_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and default vectors for the IF-stage program counter sequencer.
package pc_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      HOLD      = 2'd1,
      HOLD_PEND = 2'd2
   } pcState_e;

   typedef enum logic [1:0] {
      SRC_SEQ = 2'd0,
      SRC_BR  = 2'd1,
      SRC_JMP = 2'd2,
      SRC_EXC = 2'd3
   } redirSrc_e;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_incrementor.sv
// Combinational PC + INC, modulo 2^WIDTH.
module pc_incrementor #(
   parameter int WIDTH = 32,
   parameter int INC   = 4
) (
   input  logic [WIDTH-1:0] pcIn,
   output logic [WIDTH-1:0] pcNext
);

   assign pcNext = pcIn + WIDTH'(INC);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and next-PC sequencer: prioritised redirects, stall hold with
// redirect capture, target alignment and a one-cycle misalignment pulse.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter int               INC          = 4,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
   parameter int               ALIGN        = 2,
   parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Stall,
   input  logic             BranchTaken,
   input  logic [WIDTH-1:0] BranchTarget,
   input  logic             Jump,
   input  logic [WIDTH-1:0] JumpTarget,
   input  logic             Exception,
   output logic [WIDTH-1:0] PCResult,
   output logic [WIDTH-1:0] PCAddResult,
   output logic             RedirectPending,
   output logic             AlignErr,
   output pcState_e         DebugState
);

   localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'((64'd1 << ALIGN) - 64'd1);

   pcState_e         state, nextState;
   redirSrc_e        latchSrc, nextLatchSrc, curSrc;
   logic [WIDTH-1:0] pcReg, nextPc, pcPlus;
   logic [WIDTH-1:0] latchTarget, nextLatchTarget;
   logic [WIDTH-1:0] rawTarget, curTarget;
   logic             alignErrReg, nextAlignErr;
   logic             redirValid, curMisaligned, keepExc;

   pc_incrementor #(.WIDTH(WIDTH), .INC(INC)) uInc (
      .pcIn   (pcReg),
      .pcNext (pcPlus)
   );

   always_comb begin
      rawTarget = BranchTarget;
      curSrc    = SRC_SEQ;
      if (Exception) begin
         rawTarget = EXC_VECTOR;
         curSrc    = SRC_EXC;
      end else if (Jump) begin
         rawTarget = JumpTarget;
         curSrc    = SRC_JMP;
      end else if (BranchTaken) begin
         curSrc    = SRC_BR;
      end
   end

   // The exception vector is trusted; only jump/branch targets are aligned.
   assign redirValid    = (curSrc != SRC_SEQ);
   assign curMisaligned = (curSrc == SRC_BR || curSrc == SRC_JMP) && |(rawTarget & LOW_MASK);
   assign curTarget     = (curSrc == SRC_EXC) ? rawTarget : (rawTarget & ~LOW_MASK);
   assign keepExc       = (latchSrc == SRC_EXC) && (curSrc != SRC_EXC);

   always_comb begin
      nextState       = state;
      nextPc          = pcReg;
      nextLatchTarget = latchTarget;
      nextLatchSrc    = latchSrc;
      nextAlignErr    = 1'b0;
      case (state)
         RUN, HOLD: begin
            if (!Stall) begin
               nextState    = RUN;
               nextPc       = redirValid ? curTarget : pcPlus;
               nextAlignErr = curMisaligned;
            end else if (redirValid) begin
               nextState       = HOLD_PEND;
               nextLatchTarget = curTarget;
               nextLatchSrc    = curSrc;
               nextAlignErr    = curMisaligned;
            end else begin
               nextState = HOLD;
            end
         end
         HOLD_PEND: begin
            if (!Stall) begin
               nextState       = RUN;
               nextLatchTarget = '0;
               nextLatchSrc    = SRC_SEQ;
               if (redirValid && !keepExc) begin
                  nextPc       = curTarget;
                  nextAlignErr = curMisaligned;
               end else begin
                  nextPc = latchTarget;
               end
            end else if (redirValid && !keepExc) begin
               nextLatchTarget = curTarget;
               nextLatchSrc    = curSrc;
               nextAlignErr    = curMisaligned;
            end
         end
         default: nextState = RUN;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= RUN;
         pcReg       <= RESET_VECTOR;
         latchTarget <= '0;
         latchSrc    <= SRC_SEQ;
         alignErrReg <= 1'b0;
      end else begin
         state       <= nextState;
         pcReg       <= nextPc;
         latchTarget <= nextLatchTarget;
         latchSrc    <= nextLatchSrc;
         alignErrReg <= nextAlignErr;
      end
   end

   assign PCResult        = pcReg;
   assign PCAddResult     = pcPlus;
   assign RedirectPending = (state == HOLD_PEND);
   assign AlignErr        = alignErrReg;
   assign DebugState      = state;

endmodule
